// File: rtl/rbin_stream_tx_if.sv
// rtl/rbin_stream_tx_if.sv - hit input and r-bin stream handshake bundle
interface rbin_stream_tx_if #(
   parameter int R_WIDTH = 12
);
   logic [R_WIDTH-1:0] hit_r;
   logic               hit_last;
   logic               hit_vld;
   logic               hit_rdy;
   logic [7:0]         r_bin_V_TDATA;
   logic               r_bin_V_TVALID;
   logic               r_bin_V_TREADY;

   modport master (
      input  hit_r, hit_last, hit_vld, r_bin_V_TREADY,
      output hit_rdy, r_bin_V_TDATA, r_bin_V_TVALID
   );

   modport slave (
      output hit_r, hit_last, hit_vld, r_bin_V_TREADY,
      input  hit_rdy, r_bin_V_TDATA, r_bin_V_TVALID
   );
endinterface

// File: rtl/rbin_stream_tx.sv
// rtl/rbin_stream_tx.sv - r-bin producer: clear, quantise, buffer, stream, flush
module rbin_stream_tx #(
   parameter int RBINS        = 128,
   parameter int R_WIDTH      = 12,
   parameter int BIN_SHIFT    = 3,
   parameter int FIFO_DEPTH   = 16,
   parameter int CLEAR_CYCLES = 2,
   parameter int FLUSH_CYCLES = 3
) (
   input  logic               clk,
   input  logic               rst,
   rbin_stream_tx_if.master   io,
   input  logic               event_start,
   input  logic [R_WIDTH-1:0] r_offset,
   output logic               enable_V,
   output logic               reset_rbins,
   output logic [7:0]         oor_count,
   output logic               event_done
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, CLEAR, STREAM, FLUSH, DONE} state_t;
   state_t state, state_nx;

   logic [7:0]         cnt;
   logic               last_seen;
   logic [R_WIDTH-1:0] r_off;
   logic               q_vld, q_last;
   logic [7:0]         q_data;
   logic [8:0]         mem [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic [AW:0]        count;
   logic               out_last;

   logic               accept, push, pop, load, last_hs, fifo_full, oor;
   logic [R_WIDTH:0]   diff;
   logic [R_WIDTH-1:0] shifted;
   logic [7:0]         quant;

   // Signed difference carried in one extra bit; its MSB flags hit_r below r_offset.
   assign diff    = {1'b0, io.hit_r} - {1'b0, r_off};
   assign shifted = diff[R_WIDTH-1:0] >> BIN_SHIFT;
   assign oor     = diff[R_WIDTH] || (shifted >= R_WIDTH'(RBINS));
   assign quant   = oor ? 8'hFF : {1'b0, shifted[6:0]};

   // The quantise stage counts toward occupancy so 16 queued plus 1 output is the limit.
   assign fifo_full = (count == (AW+1)'(FIFO_DEPTH)) ||
                      (q_vld && count == (AW+1)'(FIFO_DEPTH - 1));
   assign accept  = (state == STREAM) && io.hit_vld && io.hit_rdy;
   assign push    = q_vld;
   assign load    = !io.r_bin_V_TVALID || io.r_bin_V_TREADY;
   assign pop     = load && (count != '0);
   assign last_hs = io.r_bin_V_TVALID && io.r_bin_V_TREADY && out_last;

   always_comb begin
      state_nx    = state;
      reset_rbins = 1'b0;
      enable_V    = 1'b0;
      io.hit_rdy  = 1'b0;
      event_done  = 1'b0;
      case (state)
         IDLE:   if (event_start) state_nx = CLEAR;
         CLEAR: begin
            reset_rbins = 1'b1;
            if (cnt == 8'(CLEAR_CYCLES - 1)) state_nx = STREAM;
         end
         STREAM: begin
            enable_V   = 1'b1;
            io.hit_rdy = !fifo_full && !last_seen;
            if (last_hs) state_nx = FLUSH;
         end
         FLUSH: begin
            enable_V = 1'b1;
            if (cnt == 8'(FLUSH_CYCLES - 1)) state_nx = DONE;
         end
         DONE: begin
            event_done = 1'b1;
            state_nx   = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         last_seen <= 1'b0;
         r_off     <= '0;
         oor_count <= '0;
         q_vld     <= 1'b0;
         q_last    <= 1'b0;
         q_data    <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         out_last  <= 1'b0;
         io.r_bin_V_TVALID <= 1'b0;
         io.r_bin_V_TDATA  <= '0;
      end else begin
         state <= state_nx;
         cnt   <= (state_nx != state) ? 8'd0 : cnt + 8'd1;
         if (state == IDLE && event_start) begin
            r_off     <= r_offset;
            oor_count <= '0;
            last_seen <= 1'b0;
         end
         if (accept) begin
            last_seen <= last_seen | io.hit_last;
            q_data    <= quant;
            q_last    <= io.hit_last;
            if (oor && oor_count != 8'hFF) oor_count <= oor_count + 8'd1;
         end
         q_vld <= accept;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
         if (load) begin
            io.r_bin_V_TVALID <= (count != '0);
            if (count != '0) {out_last, io.r_bin_V_TDATA} <= mem[rd_ptr];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {q_last, q_data};
   end
endmodule

// File: tb/tb_rbin_stream_tx.sv
// tb/tb_rbin_stream_tx.sv - directed self-checking bench for rbin_stream_tx
module tb_rbin_stream_tx;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        event_start = 1'b0;
   logic [11:0] r_offset = '0;
   logic        enable_V, reset_rbins, event_done;
   logic [7:0]  oor_count;

   rbin_stream_tx_if #(.R_WIDTH(12)) io();

   rbin_stream_tx dut (
      .clk(clk), .rst(rst), .io(io), .event_start(event_start), .r_offset(r_offset),
      .enable_V(enable_V), .reset_rbins(reset_rbins), .oor_count(oor_count),
      .event_done(event_done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int tready_mode = 1;
   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   int rr_cnt = 0, done_cnt = 0, flush_cnt = 0, drop_errs = 0;
   logic post_last = 1'b0, prev_v = 1'b0, prev_r = 1'b0;
   logic [7:0] prev_d = '0;

   always @(posedge clk) begin
      #1;
      case (tready_mode)
         0:       io.r_bin_V_TREADY = 1'b0;
         1:       io.r_bin_V_TREADY = 1'b1;
         default: io.r_bin_V_TREADY = 1'($urandom_range(0, 1));
      endcase
   end

   always @(negedge clk) begin
      if (rst) begin
         prev_v    <= 1'b0;
         post_last <= 1'b0;
      end else begin
         if (io.r_bin_V_TVALID && io.r_bin_V_TREADY) begin
            if (rx_q.size() == exp_q.size() - 1) begin
               post_last <= 1'b1;
               flush_cnt <= 0;
            end
            rx_q.push_back(io.r_bin_V_TDATA);
         end else if (post_last) begin
            if (enable_V) flush_cnt <= flush_cnt + 1;
            else          post_last <= 1'b0;
         end
         if (reset_rbins) rr_cnt <= rr_cnt + 1;
         if (event_done)  done_cnt <= done_cnt + 1;
         if (prev_v && !prev_r && (!io.r_bin_V_TVALID || io.r_bin_V_TDATA !== prev_d))
            drop_errs <= drop_errs + 1;
         prev_v <= io.r_bin_V_TVALID;
         prev_r <= io.r_bin_V_TREADY;
         prev_d <= io.r_bin_V_TDATA;
      end
   end

   function automatic logic [7:0] qm(input int r, input int off);
      int d;
      if (r < off) return 8'hFF;
      d = (r - off) / 8;
      if (d > 127) return 8'hFF;
      return 8'(d);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic start_event(input int off);
      @(posedge clk); #1;
      r_offset    = 12'(off);
      event_start = 1'b1;
      @(posedge clk); #1;
      event_start = 1'b0;
   endtask

   task automatic send_hit(input int r, input logic last);
      int w;
      w = 0;
      io.hit_r    = 12'(r);
      io.hit_last = last;
      io.hit_vld  = 1'b1;
      @(negedge clk);
      while (!io.hit_rdy && w < 2000) begin
         @(negedge clk);
         w++;
      end
      if (w >= 2000) begin
         tests++;
         fails++;
         $error("FAIL hit_accept_timeout: got %0d cycles expected < 2000", w);
      end
      @(posedge clk); #1;
      io.hit_vld = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int w;
      w = 0;
      @(negedge clk);
      while (!event_done && w < 400) begin
         @(negedge clk);
         w++;
      end
      chk(tag, 32'(w < 400), 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   task automatic check_stream(input string tag);
      int mism;
      mism = 0;
      chk({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
         if (rx_q[i] !== exp_q[i]) mism++;
      chk({tag, "_data"}, 32'(mism), 32'd0);
   endtask

   initial begin
      int rr0, dn0, n;
      io.hit_r = '0; io.hit_last = 1'b0; io.hit_vld = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tvalid", 32'(io.r_bin_V_TVALID), 32'd0);
      chk("rst_tdata", 32'(io.r_bin_V_TDATA), 32'd0);
      chk("rst_hit_rdy", 32'(io.hit_rdy), 32'd0);
      chk("rst_enable", 32'(enable_V), 32'd0);
      chk("rst_reset_rbins", 32'(reset_rbins), 32'd0);
      chk("rst_oor", 32'(oor_count), 32'd0);
      chk("rst_done", 32'(event_done), 32'd0);
      rst = 1'b0;

      // 1: basic binning, clear/flush windows
      rr0 = rr_cnt; dn0 = done_cnt;
      exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h7F);
      start_event(100);
      send_hit(100, 1'b0);
      send_hit(108, 1'b0);
      send_hit(1123, 1'b1);
      wait_done("t1_done_timeout");
      chk("t1_clear_cycles", 32'(rr_cnt - rr0), 32'd2);
      check_stream("t1_stream");
      chk("t1_flush_cycles", 32'(flush_cnt), 32'd3);
      chk("t1_done_pulses", 32'(done_cnt - dn0), 32'd1);
      chk("t1_oor", 32'(oor_count), 32'd0);

      // 2: out-of-range below and above
      exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
      start_event(100);
      send_hit(99, 1'b0);
      send_hit(1124, 1'b1);
      wait_done("t2_done_timeout");
      check_stream("t2_stream");
      chk("t2_oor", 32'(oor_count), 32'd2);

      // 3: full backpressure, 17 hits buffered then release
      tready_mode = 0;
      for (int i = 0; i < 20; i++) exp_q.push_back(8'(i + 2));
      start_event(0);
      n = 0;
      io.hit_r = 12'd16; io.hit_last = 1'b0; io.hit_vld = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (io.hit_rdy) n++;
         @(posedge clk); #1;
         io.hit_r = 12'(16 + n * 8);
      end
      io.hit_vld = 1'b0;
      chk("t3_accepted", 32'(n), 32'd17);
      chk("t3_hit_rdy_low", 32'(io.hit_rdy), 32'd0);
      chk("t3_tvalid_held", 32'(io.r_bin_V_TVALID), 32'd1);
      chk("t3_tdata_held", 32'(io.r_bin_V_TDATA), 32'h02);
      tready_mode = 1;
      send_hit(16 + 17 * 8, 1'b0);
      send_hit(16 + 18 * 8, 1'b0);
      send_hit(16 + 19 * 8, 1'b1);
      wait_done("t3_done_timeout");
      check_stream("t3_stream");
      chk("t3_no_drop", 32'(drop_errs), 32'd0);

      // 4: random backpressure
      tready_mode = 2;
      for (int i = 0; i < 64; i++) exp_q.push_back(qm((i * 53 + 7) % 1200, 50));
      start_event(50);
      for (int i = 0; i < 64; i++) send_hit((i * 53 + 7) % 1200, 1'(i == 63));
      wait_done("t4_done_timeout");
      check_stream("t4_stream");
      chk("t4_no_drop", 32'(drop_errs), 32'd0);

      // 5: reset mid-stream aborts, next event is clean
      tready_mode = 0;
      dn0 = done_cnt;
      start_event(0);
      for (int i = 0; i < 5; i++) send_hit(8 * i, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("t5_tvalid", 32'(io.r_bin_V_TVALID), 32'd0);
      chk("t5_enable", 32'(enable_V), 32'd0);
      chk("t5_hit_rdy", 32'(io.hit_rdy), 32'd0);
      chk("t5_tdata", 32'(io.r_bin_V_TDATA), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      tready_mode = 1;
      exp_q.push_back(8'h05); exp_q.push_back(8'h06);
      start_event(0);
      send_hit(40, 1'b0);
      send_hit(48, 1'b1);
      wait_done("t5_done_timeout");
      check_stream("t5_stream");
      chk("t5_done_pulses", 32'(done_cnt - dn0), 32'd1);

      // 6: ignored event_start in STREAM/FLUSH, oor saturation
      rr0 = rr_cnt; dn0 = done_cnt;
      for (int i = 0; i < 300; i++) exp_q.push_back(8'hFF);
      start_event(100);
      for (int i = 0; i < 300; i++) begin
         send_hit(0, 1'(i == 299));
         if (i == 10) begin
            event_start = 1'b1;
            @(posedge clk); #1;
            event_start = 1'b0;
         end
      end
      n = 0;
      @(negedge clk);
      while (!post_last && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t6_flush_reached", 32'(n < 50), 32'd1);
      @(posedge clk); #1;
      event_start = 1'b1;
      @(posedge clk); #1;
      event_start = 1'b0;
      wait_done("t6_done_timeout");
      repeat (4) @(posedge clk);
      #1;
      chk("t6_clear_cycles", 32'(rr_cnt - rr0), 32'd2);
      chk("t6_flush_cycles", 32'(flush_cnt), 32'd3);
      chk("t6_done_pulses", 32'(done_cnt - dn0), 32'd1);
      chk("t6_oor_sat", 32'(oor_count), 32'd255);
      chk("t6_enable_idle", 32'(enable_V), 32'd0);
      check_stream("t6_stream");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/rbin_stream_tx.md
Name: rbin_stream_tx

Overview:
- Producer end of the LSF r-bin stream; drives the r-bin TDATA/TVALID/TREADY interface, enable_V and reset_rbins into the histogram updater.
- Per event: clears the histogram, quantises incoming hit radii into 7-bit r-bins (bit 7 = out-of-range flag), buffers them in a FIFO, streams them with backpressure, then holds enable for a flush window so the updater's local-max result settles before event_done.

Parameters:
- RBINS, 128, number of histogram bins; fixed at 128 (7-bit bin index).
- R_WIDTH, 12, width of hit radius and r_offset (unsigned).
- BIN_SHIFT, 3, right shift applied to (hit_r - r_offset) to form the bin.
- FIFO_DEPTH, 16, bin FIFO entries; power of 2.
- CLEAR_CYCLES, 2, cycles reset_rbins is held high at event start.
- FLUSH_CYCLES, 3, cycles enable_V stays high after the last beat handshakes.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- event_start  in  1  single-cycle pulse that begins an event; honoured only in IDLE.
- r_offset  in  R_WIDTH  radius of bin 0; sampled on accepted event_start.
- hit_r  in  R_WIDTH  hit radius.
- hit_last  in  1  marks the final hit of the event.
- hit_vld  in  1  hit valid.
- hit_rdy  out  1  hit ready.
- r_bin_V_TDATA  out  8  {oor, bin[6:0]}.
- r_bin_V_TVALID  out  1  stream valid.
- r_bin_V_TREADY  in  1  stream ready from the updater.
- enable_V  out  1  updater enable.
- reset_rbins  out  1  updater histogram clear.
- oor_count  out  8  saturating count of out-of-range hits in the current event.
- event_done  out  1  single-cycle pulse at event end.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, counters 0. Asserting rst mid-event aborts the event immediately; no event_done is generated.
- FSM states: IDLE, CLEAR, STREAM, FLUSH, DONE.
- IDLE:
  - event_start moves to CLEAR, latches r_offset and zeroes oor_count.
  - Outputs idle: hit_rdy=0, enable_V=0, reset_rbins=0.
- CLEAR:
  - reset_rbins=1 for exactly CLEAR_CYCLES cycles, with enable_V=0 and hit_rdy=0.
  - Then moves to STREAM.
- STREAM:
  - enable_V=1; hit_rdy = !fifo_full.
  - A hit is accepted when hit_vld && hit_rdy.
  - Once a hit with hit_last=1 is accepted, hit_rdy=0 for the rest of the event.
- Quantisation (at accept, registered into the FIFO with its last flag):
  - diff = hit_r - r_offset_latched, computed R_WIDTH+1 bits signed.
  - If diff < 0 or (diff >> BIN_SHIFT) >= RBINS: TDATA = 8'hFF and oor_count increments, saturating at 255.
  - Otherwise TDATA = {1'b0, (diff >> BIN_SHIFT)[6:0]}.
  - Out-of-range beats are still transmitted; the updater discards them.
- Output stage:
  - Single register, loaded from the FIFO when !TVALID || TREADY.
  - TDATA is stable and TVALID stays high until the handshake completes; TVALID never drops without a handshake.
  - With an empty FIFO and a free output register, a hit accepted at edge k gives TVALID=1 after edge k+2.
  - Sustained throughput is 1 beat/cycle while TREADY=1.
- Full FIFO: a simultaneous push and pop is allowed; hit_rdy is based on the registered full flag (no combinational path from TREADY to hit_rdy).
- End of stream: when the beat carrying last handshakes, move to FLUSH.
- Event with no hits: the event is still ended by a hit with hit_last=1; there is no empty-event bypass.
- FLUSH: enable_V=1, TVALID=0, for FLUSH_CYCLES cycles; then DONE.
- DONE: event_done=1 for one cycle, enable_V=0, then IDLE.
- event_start in any state other than IDLE is ignored.
- oor_count holds its value after the event until the next accepted event_start.

Test Plan:
1. r_offset=100, BIN_SHIFT=3, hits r=100, 108, 1123(last), TREADY=1 -> reset_rbins high 2 cycles; TDATA sequence 0x00, 0x01, 0x7F; enable_V held 3 cycles past the last handshake; one event_done pulse; oor_count=0.
2. r_offset=100, hits r=99 and r=1124(last) -> both beats TDATA=0xFF; oor_count=2.
3. 20 hits with TREADY=0 -> hit_rdy drops after 16 FIFO entries plus 1 in the output register; TDATA holds its value while stalled. Then TREADY=1 -> all 20 beats delivered in order, none lost or duplicated.
4. Random TREADY with 50% duty over 64 hits -> output order matches input order; TVALID never deasserts without a handshake.
5. Assert rst during STREAM with 5 beats queued -> all outputs 0 immediately and the FIFO is empty. A following event_start runs a clean event whose first beat is the new event's first hit.
6. event_start pulsed during STREAM and during FLUSH -> ignored: no extra reset_rbins and no state change. 300 out-of-range hits in one event -> oor_count saturates at 255.
